// File: rtl/program_sequencer.sv
// program_sequencer
//   Program counter for the instruction-memory address. Supports stall,
//   absolute jump, PC-relative branch and a bounded hardware call/return
//   stack. Refused calls (stack full) and refused returns (stack empty) fall
//   through to a plain increment and raise a one-cycle error pulse.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; loads RESET_VEC, empties the stack
//   en         advance enable; 0 holds all state and ignores commands
//   jump       absolute jump to jump_addr
//   jump_addr  target for jump and call
//   branch     relative branch by signed br_off from the current pc
//   br_off     two's complement branch offset
//   call       push pc+1, go to jump_addr
//   ret        pop return address into pc
//   pc         current program counter (registered)
//   depth      number of valid stack entries (registered)
//   ovf        one-cycle pulse: call refused because the stack is full
//   unf        one-cycle pulse: ret refused because the stack is empty
//
// Command priority: reset > en=0 > ret > call > jump > branch > increment.
// Losing requests in the same cycle are dropped.

module program_sequencer #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      OFF_W       = 8,
    parameter int unsigned      STACK_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VEC   = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               en,
    input  logic                               jump,
    input  logic [WIDTH-1:0]                   jump_addr,
    input  logic                               branch,
    input  logic [OFF_W-1:0]                   br_off,
    input  logic                               call,
    input  logic                               ret,
    output logic [WIDTH-1:0]                   pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               ovf,
    output logic                               unf
);

    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
    // Stack address width; kept at least 1 bit so a single-entry stack still
    // has a legal index.
    localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH_FULL = DW'(STACK_DEPTH);

    logic [WIDTH-1:0] stack [2**AW];

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] off_ext;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [DW-1:0]    depth_m1;

    logic [WIDTH-1:0] pc_n;
    logic [DW-1:0]    depth_n;
    logic             ovf_n;
    logic             unf_n;
    logic             push;

    assign pc_inc   = pc + WIDTH'(1);
    // Size cast of a signed operand sign-extends; also legal when OFF_W == WIDTH.
    assign off_ext  = WIDTH'($signed(br_off));
    assign depth_m1 = depth - DW'(1);
    assign wr_idx   = AW'(depth);
    assign rd_idx   = AW'(depth_m1);

    always_comb begin
        pc_n    = pc;
        depth_n = depth;
        ovf_n   = 1'b0;
        unf_n   = 1'b0;
        push    = 1'b0;
        if (en) begin
            if (ret) begin
                if (depth != '0) begin
                    pc_n    = stack[rd_idx];
                    depth_n = depth_m1;
                end else begin
                    pc_n  = pc_inc;
                    unf_n = 1'b1;
                end
            end else if (call) begin
                if (depth != DEPTH_FULL) begin
                    push    = 1'b1;
                    pc_n    = jump_addr;
                    depth_n = depth + DW'(1);
                end else begin
                    pc_n  = pc_inc;
                    ovf_n = 1'b1;
                end
            end else if (jump) begin
                pc_n = jump_addr;
            end else if (branch) begin
                pc_n = pc + off_ext;
            end else begin
                pc_n = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_VEC;
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            pc    <= pc_n;
            depth <= depth_n;
            ovf   <= ovf_n;
            unf   <= unf_n;
        end
    end

    // Stack storage is not reset; only depth decides which entries are valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            stack[wr_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       reset, en, jump, branch, call, ret;
    logic [7:0] jump_addr, br_off;
    logic [7:0] pc, pc2;
    logic [2:0] depth, depth2;
    logic       ovf, unf, ovf2, unf2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    program_sequencer #(.WIDTH(8), .OFF_W(8), .STACK_DEPTH(4), .RESET_VEC(8'h00)) dut (
        .clk(clk), .reset(reset), .en(en), .jump(jump), .jump_addr(jump_addr),
        .branch(branch), .br_off(br_off), .call(call), .ret(ret),
        .pc(pc), .depth(depth), .ovf(ovf), .unf(unf)
    );

    program_sequencer #(.WIDTH(8), .OFF_W(8), .STACK_DEPTH(4), .RESET_VEC(8'hC0)) dut_rv (
        .clk(clk), .reset(reset), .en(en), .jump(jump), .jump_addr(jump_addr),
        .branch(branch), .br_off(br_off), .call(call), .ret(ret),
        .pc(pc2), .depth(depth2), .ovf(ovf2), .unf(unf2)
    );

    task automatic idle();
        reset = 1'b0; en = 1'b1; jump = 1'b0; branch = 1'b0;
        call = 1'b0; ret = 1'b0; jump_addr = 8'h00; br_off = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        checks++;
        if ({pc, depth, ovf, unf} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: pc=%h depth=%0d ovf=%b unf=%b, need pc=00 depth=0 ovf=0 unf=0",
                     pc, depth, ovf, unf);
        end
        checks++;
        if (pc2 !== 8'hC0 || depth2 !== 3'd0) begin
            errors++;
            $display("FAIL reset_vec: pc=%h depth=%0d, need pc=c0 depth=0", pc2, depth2);
        end
    endtask

    task automatic test_increment();
        logic [7:0] exp_pc;
        idle();
        exp_pc = 8'h00;
        for (int i = 1; i < 260; i++) begin
            tick();
            exp_pc = exp_pc + 8'h01;
            checks++;
            if (pc !== exp_pc || depth !== 3'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
                errors++;
                $display("FAIL increment[%0d]: pc=%h depth=%0d ovf=%b unf=%b, need pc=%h depth=0 no flags",
                         i, pc, depth, ovf, unf, exp_pc);
            end
        end
    endtask

    task automatic test_branch();
        idle(); jump = 1'b1; jump_addr = 8'h10; tick();
        idle(); branch = 1'b1; br_off = 8'hFC; tick();
        checks++;
        if (pc !== 8'h0C) begin
            errors++; $display("FAIL branch_back: pc=%h, need 0c", pc);
        end
        idle(); jump = 1'b1; jump_addr = 8'hF0; tick();
        idle(); branch = 1'b1; br_off = 8'h7F; tick();
        checks++;
        if (pc !== 8'h6F) begin
            errors++; $display("FAIL branch_wrap_up: pc=%h, need 6f", pc);
        end
        idle(); jump = 1'b1; jump_addr = 8'h02; tick();
        idle(); branch = 1'b1; br_off = 8'hFC; tick();
        checks++;
        if (pc !== 8'hFE) begin
            errors++; $display("FAIL branch_wrap_down: pc=%h, need fe", pc);
        end
    endtask

    task automatic test_call_ret();
        idle(); jump = 1'b1; jump_addr = 8'h20; tick();
        idle(); call = 1'b1; jump_addr = 8'h80; tick();
        checks++;
        if (pc !== 8'h80 || depth !== 3'd1) begin
            errors++; $display("FAIL call: pc=%h depth=%0d, need pc=80 depth=1", pc, depth);
        end
        idle(); ret = 1'b1; tick();
        checks++;
        if (pc !== 8'h21 || depth !== 3'd0) begin
            errors++; $display("FAIL ret: pc=%h depth=%0d, need pc=21 depth=0", pc, depth);
        end
    endtask

    task automatic test_nested();
        logic [7:0] tgt [5];
        logic [7:0] rtn [4];
        tgt = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h90};
        rtn = '{8'h61, 8'h51, 8'h41, 8'h31};
        idle(); jump = 1'b1; jump_addr = 8'h30; tick();
        for (int i = 0; i < 4; i++) begin
            idle(); call = 1'b1; jump_addr = tgt[i]; tick();
            checks++;
            if (pc !== tgt[i] || depth !== 3'(i + 1) || ovf !== 1'b0) begin
                errors++;
                $display("FAIL nested_call[%0d]: pc=%h depth=%0d ovf=%b, need pc=%h depth=%0d ovf=0",
                         i, pc, depth, ovf, tgt[i], i + 1);
            end
        end
        idle(); call = 1'b1; jump_addr = tgt[4]; tick();
        checks++;
        if (pc !== 8'h71 || depth !== 3'd4 || ovf !== 1'b1 || unf !== 1'b0) begin
            errors++;
            $display("FAIL overflow: pc=%h depth=%0d ovf=%b unf=%b, need pc=71 depth=4 ovf=1 unf=0",
                     pc, depth, ovf, unf);
        end
        for (int i = 0; i < 4; i++) begin
            idle(); ret = 1'b1; tick();
            checks++;
            if (pc !== rtn[i] || depth !== 3'(3 - i) || ovf !== 1'b0 || unf !== 1'b0) begin
                errors++;
                $display("FAIL nested_ret[%0d]: pc=%h depth=%0d ovf=%b unf=%b, need pc=%h depth=%0d no flags",
                         i, pc, depth, ovf, unf, rtn[i], 3 - i);
            end
        end
        idle(); ret = 1'b1; tick();
        checks++;
        if (pc !== 8'h32 || depth !== 3'd0 || unf !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL underflow: pc=%h depth=%0d ovf=%b unf=%b, need pc=32 depth=0 ovf=0 unf=1",
                     pc, depth, ovf, unf);
        end
        idle(); tick();
        checks++;
        if (pc !== 8'h33 || unf !== 1'b0) begin
            errors++; $display("FAIL unf_pulse: pc=%h unf=%b, need pc=33 unf=0", pc, unf);
        end
    endtask

    task automatic test_priority();
        idle(); ret = 1'b1; call = 1'b1; jump_addr = 8'hA0; tick();
        checks++;
        if (pc !== 8'h34 || depth !== 3'd0 || unf !== 1'b1) begin
            errors++;
            $display("FAIL ret_over_call: pc=%h depth=%0d unf=%b, need pc=34 depth=0 unf=1", pc, depth, unf);
        end
        idle(); call = 1'b1; jump = 1'b1; branch = 1'b1; jump_addr = 8'hA0; br_off = 8'h10; tick();
        checks++;
        if (pc !== 8'hA0 || depth !== 3'd1 || unf !== 1'b0) begin
            errors++;
            $display("FAIL call_wins: pc=%h depth=%0d unf=%b, need pc=a0 depth=1 unf=0", pc, depth, unf);
        end
        idle(); ret = 1'b1; jump = 1'b1; jump_addr = 8'h11; tick();
        checks++;
        if (pc !== 8'h35 || depth !== 3'd0) begin
            errors++; $display("FAIL ret_over_jump: pc=%h depth=%0d, need pc=35 depth=0", pc, depth);
        end
        idle(); jump = 1'b1; branch = 1'b1; jump_addr = 8'h77; br_off = 8'h05; tick();
        checks++;
        if (pc !== 8'h77) begin
            errors++; $display("FAIL jump_over_branch: pc=%h, need 77", pc);
        end
        idle(); en = 1'b0; jump = 1'b1; jump_addr = 8'h12; tick();
        checks++;
        if (pc !== 8'h77 || ovf !== 1'b0 || unf !== 1'b0) begin
            errors++;
            $display("FAIL stall_jump: pc=%h ovf=%b unf=%b, need pc=77 no flags", pc, ovf, unf);
        end
        idle(); en = 1'b0; ret = 1'b1; tick();
        checks++;
        if (pc !== 8'h77 || depth !== 3'd0 || unf !== 1'b0) begin
            errors++;
            $display("FAIL stall_ret: pc=%h depth=%0d unf=%b, need pc=77 depth=0 unf=0", pc, depth, unf);
        end
        idle(); en = 1'b0; reset = 1'b1; tick();
        checks++;
        if (pc !== 8'h00 || depth !== 3'd0 || pc2 !== 8'hC0) begin
            errors++;
            $display("FAIL stall_reset: pc=%h depth=%0d pc_rv=%h, need pc=00 depth=0 pc_rv=c0", pc, depth, pc2);
        end
    endtask

    task automatic test_reset_mid();
        idle(); call = 1'b1; jump_addr = 8'h10; tick();
        idle(); call = 1'b1; jump_addr = 8'h20; tick();
        idle(); call = 1'b1; jump_addr = 8'h55; tick();
        checks++;
        if (pc !== 8'h55 || depth !== 3'd3) begin
            errors++; $display("FAIL pre_reset: pc=%h depth=%0d, need pc=55 depth=3", pc, depth);
        end
        idle(); reset = 1'b1; call = 1'b1; jump_addr = 8'h99; tick();
        checks++;
        if ({pc, depth, ovf, unf} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: pc=%h depth=%0d ovf=%b unf=%b, need pc=00 depth=0 no flags",
                     pc, depth, ovf, unf);
        end
        checks++;
        if (pc2 !== 8'hC0 || depth2 !== 3'd0 || ovf2 !== 1'b0 || unf2 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_vec: pc=%h depth=%0d ovf=%b unf=%b, need pc=c0 depth=0 no flags",
                     pc2, depth2, ovf2, unf2);
        end
        idle(); ret = 1'b1; tick();
        checks++;
        if (pc !== 8'h01 || depth !== 3'd0 || unf !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ret: pc=%h depth=%0d unf=%b, need pc=01 depth=0 unf=1", pc, depth, unf);
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_increment();
        test_branch();
        test_call_ret();
        test_nested();
        test_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
